// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin load/store controller for a single-port byte-enabled data memory.
// Revision 1.0
`default_nettype none

module dmem_ctrl #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_we,
  input  logic [1:0][1:0]            req_size,
  input  logic [1:0]                 req_unsigned,
  input  logic [1:0][ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0][XLEN-1:0]       req_wdata,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [XLEN-1:0]            rsp_rdata,
  output logic                       rsp_err,
  output logic                       mem_we,
  output logic [XLEN/8-1:0]          mem_be,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [XLEN-1:0]            mem_wd,
  input  logic [XLEN-1:0]            mem_rd
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD_CAP = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic                  gnt;
  logic                  accept;
  logic [1:0]            sel_size;
  logic [ADDR_WIDTH+1:0] sel_addr;
  logic [1:0]            sel_off;
  logic [XLEN-1:0]       sel_wdata;
  logic                  illegal;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_ext;

  // On contention the port that lost the previous arbitration wins.
  assign gnt       = (&req_valid) ? ~last_grant_q : req_valid[1];
  assign accept    = rst_n && (state_q == IDLE) && (|req_valid);
  assign sel_size  = req_size[gnt];
  assign sel_addr  = req_addr[gnt];
  assign sel_off   = sel_addr[1:0];
  assign sel_wdata = req_wdata[gnt];
  assign illegal   = (sel_size == 2'b11) ||
                     ((sel_size == SZ_HALF) && sel_off[0]) ||
                     ((sel_size == SZ_WORD) && (sel_off != 2'b00));

  assign shifted = mem_rd >> {off_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'd0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = uns_q ? {16'd0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready    = 2'b00;
    mem_we       = 1'b0;
    mem_be       = '0;
    mem_addr     = '0;
    mem_wd       = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready    = gnt ? 2'b10 : 2'b01;
          last_grant_d = gnt;
          grant_d      = gnt;
          off_d        = sel_off;
          size_d       = sel_size;
          uns_d        = req_unsigned[gnt];
          err_d        = illegal;
          rdata_d      = '0;
          if (illegal) begin
            state_d = RESP;
          end else begin
            mem_addr = sel_addr[ADDR_WIDTH+1:2];
            if (req_we[gnt]) begin
              mem_we  = 1'b1;
              state_d = RESP;
              case (sel_size)
                SZ_BYTE: begin
                  mem_wd = {4{sel_wdata[7:0]}};
                  mem_be = 4'b0001 << sel_off;
                end
                SZ_HALF: begin
                  mem_wd = {2{sel_wdata[15:0]}};
                  mem_be = 4'b0011 << sel_off;
                end
                default: begin
                  mem_wd = sel_wdata;
                  mem_be = 4'b1111;
                end
              endcase
            end else begin
              state_d = RD_CAP;
            end
          end
        end
      end
      RD_CAP: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

endmodule

`default_nettype wire
